// File: rtl/counter_seq_arbiter.sv
// Round-robin sequencer that shares one external loadable up-counter among NUM_REQ requesters.
// Optional macro CNTSEQ_PRIO0_EN gives requester 0 fixed top priority over the round-robin group.
module counter_seq_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_op,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       cnt_load,
    output logic [WIDTH-1:0]           cnt_data,
    output logic                       cnt_en,
    input  logic [WIDTH-1:0]           cnt_q,
    output logic                       rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_value,
    input  logic                       rsp_ready,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_RESP
    } state_t;

    state_t             state, state_n;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    op_id;
    logic [WIDTH-1:0]   op_data;
    logic               cap_valid;
    logic [WIDTH-1:0]   cap_value;

    logic [NUM_REQ-1:0] rr_valid;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    win;
    logic               found;
    logic               rr_upd;
    logic               sel_op;
    logic [WIDTH-1:0]   sel_data;
    logic               accept;

    // Round-robin search starting just after the last winner
    always_comb begin
        rr_valid = req_valid;
        cand     = '0;
        win      = '0;
        found    = 1'b0;
        rr_upd   = 1'b0;
`ifdef CNTSEQ_PRIO0_EN
        rr_valid[0] = 1'b0;
`endif
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && rr_valid[cand]) begin
                found  = 1'b1;
                win    = cand;
                rr_upd = 1'b1;
            end
        end
`ifdef CNTSEQ_PRIO0_EN
        if (req_valid[0]) begin
            found  = 1'b1;
            win    = '0;
            rr_upd = 1'b0;
        end
`endif
    end

    assign sel_op   = req_op[win];
    assign sel_data = req_data[int'(win)*WIDTH +: WIDTH];
    assign accept   = (state == S_IDLE) && found;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (found) begin
                    if (sel_op)
                        state_n = S_LOAD;
                    else if (sel_data == '0)
                        state_n = S_RESP;
                    else
                        state_n = S_COUNT;
                end
            end
            S_LOAD:  state_n = S_RESP;
            S_COUNT: if (op_data == WIDTH'(1)) state_n = S_RESP;
            S_RESP:  if (rsp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            op_id     <= '0;
            op_data   <= '0;
            cap_valid <= 1'b0;
            cap_value <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_id   <= win;
                op_data <= sel_data;
                if (rr_upd)
                    rr_ptr <= win;
            end
            if (state == S_COUNT)
                op_data <= op_data - WIDTH'(1);
            // cnt_q is only final one edge after the last load/enable, i.e. in the first RESP cycle
            cap_valid <= (state == S_RESP) && (state_n == S_RESP);
            if (state == S_RESP && !cap_valid)
                cap_value <= cnt_q;
        end
    end

    always_comb begin
        req_ready = '0;
        cnt_load  = 1'b0;
        cnt_data  = '0;
        cnt_en    = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        rsp_value = '0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (found) req_ready[win] = 1'b1;
            S_LOAD: begin
                cnt_load = 1'b1;
                cnt_data = op_data;
            end
            S_COUNT: cnt_en = 1'b1;
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = op_id;
                rsp_value = cap_valid ? cap_value : cnt_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Bench for counter_seq_arbiter: directed op table, corner sequences and a randomized
// transaction-level model. Honors CNTSEQ_PRIO0_EN for the arbitration expectations.
module tb_counter_seq_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_op;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 cnt_load;
    logic [WIDTH-1:0]     cnt_data;
    logic                 cnt_en;
    logic [WIDTH-1:0]     cnt_q;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [WIDTH-1:0]     rsp_value;
    logic                 rsp_ready;
    logic                 busy;

    logic                 preset_en;
    logic [WIDTH-1:0]     preset_val;

    int checks = 0;
    int errors = 0;

    counter_seq_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_en(cnt_en), .cnt_q(cnt_q),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_value(rsp_value), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External counter datapath, with a bench-side preset to place it at a known value
    always @(posedge clk) begin
        if (preset_en)     cnt_q <= preset_val;
        else if (cnt_load) cnt_q <= cnt_data;
        else if (cnt_en)   cnt_q <= cnt_q + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic preset(input logic [7:0] v);
        preset_en = 1'b1;
        preset_val = v;
        step();
        preset_en = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        onehot_idx = -1;
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i]) onehot_idx = i;
    endfunction

    // Reference arbitration: next valid requester after the last winner, requester 0 first if prioritized
    function automatic int pick(input logic [NUM_REQ-1:0] v, input int rr);
        pick = -1;
`ifdef CNTSEQ_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (rr + k) % NUM_REQ;
`ifdef CNTSEQ_PRIO0_EN
            if (j == 0) continue;
`endif
            if (v[j]) return j;
        end
    endfunction

    typedef struct {
        int         id;
        bit         op;
        logic [7:0] data;
        logic [7:0] start;
        logic [7:0] exp_val;
        int         exp_lat;
        int         exp_en;
    } vec_t;

    vec_t vecs[7];

    task automatic run_op(input vec_t v);
        int n, en, ld;
        bit got;
        preset(v.start);
        req_valid[v.id] = 1'b1;
        req_op[v.id] = v.op;
        req_data[v.id*WIDTH +: WIDTH] = v.data;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("accept", 32'(req_ready), 32'(1 << v.id));
        step();
        req_valid = '0;
        n = 0; en = 0; ld = 0; got = 1'b0;
        while (n < 300 && !got) begin
            @(negedge clk);
            n++;
            if (rsp_valid) got = 1'b1;
            else begin
                en += int'(cnt_en);
                ld += int'(cnt_load);
            end
        end
        chk("latency", n, v.exp_lat);
        chk("en_cycles", en, v.exp_en);
        chk("load_cycles", ld, v.op ? 1 : 0);
        chk("rsp_id", 32'(rsp_id), v.id);
        chk("rsp_value", 32'(rsp_value), 32'(v.exp_val));
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int order[5];
        int exp_order[5];
        int ng, cyc, rv_seen;
        logic [7:0] h_val;

        reset = 1'b1; preset_en = 1'b0; preset_val = '0;
        req_valid = '0; req_op = '0; req_data = '0; rsp_ready = 1'b0;

        // Reset state
        do_reset();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cnt_load", cnt_load, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        step();
        reset = 1'b0;

        // Directed op table
        vecs[0] = '{0, 1'b1, 8'h5A, 8'h00, 8'h5A, 2, 0};
        vecs[1] = '{2, 1'b0, 8'd3,  8'h10, 8'h13, 4, 3};
        vecs[2] = '{1, 1'b0, 8'd3,  8'hFE, 8'h01, 4, 3};
        vecs[3] = '{3, 1'b0, 8'd0,  8'h33, 8'h33, 1, 0};
        vecs[4] = '{1, 1'b0, 8'd255, 8'h00, 8'hFF, 256, 255};
        vecs[5] = '{3, 1'b1, 8'h00, 8'h77, 8'h00, 2, 0};
        vecs[6] = '{2, 1'b0, 8'd1,  8'hFF, 8'h00, 2, 1};
        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Arbitration order with all requesters held valid
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[i] = 1'b1;
            req_data[i*WIDTH +: WIDTH] = 8'(i);
        end
        req_valid = '1;
        ng = 0; cyc = 0;
        while (ng < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                order[ng] = onehot_idx(req_ready);
                chk("rr_onehot", $countones(req_ready), 1);
                ng++;
            end
        end
        chk("rr_grants", ng, 5);
`ifdef CNTSEQ_PRIO0_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < 5; i++) chk("rr_order", order[i], exp_order[i]);
        step();
        req_valid = '0;
        repeat (6) step();
        rsp_ready = 1'b0;

        // Response backpressure
        preset(8'h00);
        req_valid[1] = 1'b1; req_op[1] = 1'b1; req_data[1*WIDTH +: WIDTH] = 8'h44;
        @(negedge clk);
        chk("bp_accept", 32'(req_ready), 32'b0010);
        step();
        req_valid[1] = 1'b0;
        req_valid[3] = 1'b1; req_op[3] = 1'b0; req_data[3*WIDTH +: WIDTH] = 8'd2;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 10);
        h_val = 8'h44;
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_id", 32'(rsp_id), 1);
            chk("bp_rsp_value", 32'(rsp_value), 32'(h_val));
            chk("bp_no_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_accept", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) step();
        rsp_ready = 1'b0;

        // Reset in the middle of a long COUNT
        do_reset();
        preset(8'h20);
        req_valid[2] = 1'b1; req_op[2] = 1'b0; req_data[2*WIDTH +: WIDTH] = 8'd10;
        @(negedge clk);
        chk("mr_accept", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_counting", cnt_en, 1);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mr_cnt_en", cnt_en, 0);
        chk("mr_busy", busy, 0);
        rv_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rv_seen += int'(rsp_valid);
        end
        chk("mr_no_rsp", rv_seen, 0);
        step();
        req_valid = '1;
        @(negedge clk);
        chk("mr_first_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();

        // Randomized traffic against a transaction-level model
        do_reset();
        preset(8'h00);
        begin
            bit         m_idle;
            int         m_rr, m_id, m_due, m_en_exp, m_en_seen, w;
            logic [7:0] m_cnt, m_val;
            logic [NUM_REQ-1:0] acc;
            m_idle = 1'b1; m_rr = NUM_REQ - 1; m_cnt = 8'h00;
            m_id = 0; m_due = 0; m_en_exp = 0; m_en_seen = 0; m_val = '0;
            acc = '0;
            for (int c = 0; c < 1500; c++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (acc[i]) req_valid[i] = 1'b0;
                    else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                    if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_op[i] = 1'($urandom_range(0, 1));
                        req_data[i*WIDTH +: WIDTH] = req_op[i] ? 8'($urandom) : 8'($urandom_range(0, 6));
                    end
                end
                rsp_ready = ($urandom_range(0, 2) != 0);
                @(negedge clk);
                chk("rnd_excl", 32'(cnt_load & cnt_en), 0);
                if (m_idle) begin
                    w = pick(req_valid, m_rr);
                    chk("rnd_ready", 32'(req_ready), (w < 0) ? 0 : 32'(1 << w));
                    chk("rnd_idle_rsp", rsp_valid, 0);
                    if (w >= 0) begin
                        logic [7:0] d;
                        d = req_data[w*WIDTH +: WIDTH];
                        m_idle = 1'b0;
                        m_id = w;
                        m_en_seen = 0;
                        if (req_op[w]) begin
                            m_val = d; m_due = c + 2; m_en_exp = 0;
                        end else begin
                            m_val = m_cnt + d; m_due = c + int'(d) + 1; m_en_exp = int'(d);
                        end
                        m_cnt = m_val;
`ifdef CNTSEQ_PRIO0_EN
                        if (w != 0) m_rr = w;
`else
                        m_rr = w;
`endif
                    end
                end else begin
                    chk("rnd_busy_ready", 32'(req_ready), 0);
                    if (c >= m_due) begin
                        chk("rnd_rsp_valid", rsp_valid, 1);
                        chk("rnd_rsp_id", 32'(rsp_id), m_id);
                        chk("rnd_rsp_value", 32'(rsp_value), 32'(m_val));
                        if (c == m_due) chk("rnd_en_cycles", m_en_seen, m_en_exp);
                        if (rsp_ready) m_idle = 1'b1;
                    end else begin
                        chk("rnd_early_rsp", rsp_valid, 0);
                        m_en_seen += int'(cnt_en);
                    end
                end
                acc = req_ready & req_valid;
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
